duty_slew_supervisor: RTL and testbench

Upstream stage for the three motor phase drivers: it turns a commanded duty cycle into the `duty_cycle` bus that the commutation logic gates onto each phase. The output slews toward the command at a bounded rate, and the block supervises the raw hall inputs. An invalid hall code or a stalled rotor forces the duty to zero and latches a fault until software commands zero.

---
 rtl/duty_slew_supervisor.sv | 188 ++++++++++++++++++
 tb/tb_duty_slew_supervisor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duty_slew_supervisor.sv
// duty_slew_supervisor
//   Turns a commanded duty into a rate-limited duty bus for the phase drivers and
//   supervises the raw hall inputs. An illegal hall code (000/111) or, when built with
//   DUTY_SLEW_STALL_DETECT_EN, a stalled rotor forces the duty to zero and latches a
//   fault. The fault is cleared only by a zero command while the hall code is legal.
//
//   Build option: define DUTY_SLEW_STALL_DETECT_EN to build the stall watchdog and make
//   the STALL state reachable; otherwise stall is tied low.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   cmd_duty    in   commanded duty
//   cmd_valid   in   single-cycle command strobe (always accepted)
//   h           in   raw hall inputs, asynchronous to clock
//   duty_cycle  out  slewed duty to the phase drivers
//   hall_fault  out  latched invalid-hall fault
//   stall       out  latched stall fault
//   state       out  0 RUN, 1 HALL_FAULT, 2 STALL
module duty_slew_supervisor #(
   parameter int unsigned DUTY_WIDTH   = 8,
   parameter int unsigned STEP_DIV     = 256,
   parameter int unsigned SLEW_STEP    = 1,
   parameter int unsigned STALL_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DUTY_WIDTH-1:0] cmd_duty,
   input  logic                  cmd_valid,
   input  logic [2:0]            h,
   output logic [DUTY_WIDTH-1:0] duty_cycle,
   output logic                  hall_fault,
   output logic                  stall,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StHallFault = 2'd1,
      StStall     = 2'd2
   } stateT;

   localparam int unsigned PreW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned WideW = DUTY_WIDTH + 1;
   localparam logic [PreW-1:0]     PreMax = PreW'(STEP_DIV - 1);
   localparam logic [DUTY_WIDTH:0] StepW  = WideW'(SLEW_STEP);

   stateT                 fsmState;
   logic [DUTY_WIDTH-1:0] target;
   logic [2:0]            hMeta;
   logic [2:0]            hS;
   logic [1:0]            settleCnt;
   logic                  settled;
   logic                  hallBad;
   logic [PreW-1:0]       preCnt;
   logic                  tick;
   logic                  stallExpire;
   logic [DUTY_WIDTH:0]   dutyW;
   logic [DUTY_WIDTH:0]   targetW;
   logic [DUTY_WIDTH:0]   upSum;
   logic [DUTY_WIDTH:0]   dnDiff;
   logic [DUTY_WIDTH-1:0] slewNext;

   // Hall synchronizer plus a settle counter: hS holds 000 for the first two cycles
   // after reset, which must not be mistaken for an illegal hall code.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hMeta     <= 3'b000;
         hS        <= 3'b000;
         settleCnt <= 2'd0;
      end else begin
         hMeta <= h;
         hS    <= hMeta;
         if (!settled) begin
            settleCnt <= settleCnt + 2'd1;
         end
      end
   end

   assign settled = (settleCnt == 2'd2);
   assign hallBad = settled && ((hS == 3'b000) || (hS == 3'b111));

   // Free-running slew prescaler.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         preCnt <= '0;
      end else if (preCnt == PreMax) begin
         preCnt <= '0;
      end else begin
         preCnt <= preCnt + PreW'(1);
      end
   end

   assign tick = (preCnt == PreMax);

   // One-bit-wider arithmetic so a step never wraps past all-ones or below zero;
   // the result is clamped to the target so it cannot overshoot.
   always_comb begin
      dutyW    = {1'b0, duty_cycle};
      targetW  = {1'b0, target};
      upSum    = dutyW + StepW;
      dnDiff   = dutyW - StepW;
      slewNext = duty_cycle;
      if (duty_cycle < target) begin
         slewNext = (upSum > targetW) ? target : upSum[DUTY_WIDTH-1:0];
      end else if (duty_cycle > target) begin
         slewNext = (dnDiff[DUTY_WIDTH] || (dnDiff < targetW)) ? target
                                                              : dnDiff[DUTY_WIDTH-1:0];
      end
   end

`ifdef DUTY_SLEW_STALL_DETECT_EN
   localparam int unsigned WdW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
   localparam logic [WdW-1:0] WdMax = WdW'(STALL_CYCLES - 1);

   logic [2:0]     hPrev;
   logic           hallEdge;
   logic [WdW-1:0] wdCnt;

   // Stall watchdog: counts clocks of nonzero duty in RUN with no hall transition.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hPrev <= 3'b000;
         wdCnt <= '0;
      end else begin
         hPrev <= hS;
         if (hallEdge || (duty_cycle == '0) || (fsmState != StRun)) begin
            wdCnt <= '0;
         end else if (wdCnt != WdMax) begin
            wdCnt <= wdCnt + WdW'(1);
         end
      end
   end

   assign hallEdge    = (hS != hPrev);
   assign stallExpire = (fsmState == StRun) && (wdCnt == WdMax);
   assign stall       = (fsmState == StStall);
`else
   assign stallExpire = 1'b0;
   assign stall       = 1'b0;
`endif

   // Supervisor FSM with target and duty registers. Fault entry zeroes duty and target
   // on the same edge; hallBad outranks stall, and both outrank a command.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsmState   <= StRun;
         target     <= '0;
         duty_cycle <= '0;
      end else begin
         unique case (fsmState)
            StRun: begin
               if (hallBad) begin
                  fsmState   <= StHallFault;
                  target     <= '0;
                  duty_cycle <= '0;
               end else if (stallExpire) begin
                  fsmState   <= StStall;
                  target     <= '0;
                  duty_cycle <= '0;
               end else begin
                  if (cmd_valid) begin
                     target <= cmd_duty;
                  end
                  if (tick) begin
                     duty_cycle <= slewNext;
                  end
               end
            end
            StHallFault, StStall: begin
               // Only a zero command with a legal hall code leaves a fault.
               if (cmd_valid && (cmd_duty == '0) && !hallBad) begin
                  fsmState <= StRun;
               end
            end
            default: begin
               fsmState   <= StRun;
               target     <= '0;
               duty_cycle <= '0;
            end
         endcase
      end
   end

   assign state      = fsmState;
   assign hall_fault = (fsmState == StHallFault);

endmodule

// File: tb/tb_duty_slew_supervisor.sv
// Bench for duty_slew_supervisor: two instances (slew step 1 and 7) share stimulus and
// are compared every cycle against a behavioural model built from the block's rules.
module tb_duty_slew_supervisor;

   localparam int StepDiv     = 4;
   localparam int StallCycles = 64;
`ifdef DUTY_SLEW_STALL_DETECT_EN
   localparam bit StallEn = 1'b1;
`else
   localparam bit StallEn = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] cmd_duty;
   logic       cmd_valid;
   logic [2:0] h;
   logic [7:0] duty1, duty7;
   logic       hf1, hf7, st1, st7;
   logic [1:0] state1, state7;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clock = ~clock;

   duty_slew_supervisor #(
      .DUTY_WIDTH  (8),
      .STEP_DIV    (StepDiv),
      .SLEW_STEP   (1),
      .STALL_CYCLES(StallCycles)
   ) dut1 (
      .clock     (clock),
      .reset     (reset),
      .cmd_duty  (cmd_duty),
      .cmd_valid (cmd_valid),
      .h         (h),
      .duty_cycle(duty1),
      .hall_fault(hf1),
      .stall     (st1),
      .state     (state1)
   );

   duty_slew_supervisor #(
      .DUTY_WIDTH  (8),
      .STEP_DIV    (StepDiv),
      .SLEW_STEP   (7),
      .STALL_CYCLES(StallCycles)
   ) dut7 (
      .clock     (clock),
      .reset     (reset),
      .cmd_duty  (cmd_duty),
      .cmd_valid (cmd_valid),
      .h         (h),
      .duty_cycle(duty7),
      .hall_fault(hf7),
      .stall     (st7),
      .state     (state7)
   );

   // ---------------- reference model ----------------
   int         stepOf  [2] = '{1, 7};
   int         mDuty   [2];
   int         mTarget [2];
   int         mState  [2];   // 0 run, 1 hall fault, 2 stall
   int         mQuiet  [2];   // clocks of nonzero duty in run without a hall change
   int         phase;         // clocks since reset, modulo StepDiv
   int         sinceReset;
   logic [2:0] seen [3];      // pin value sampled 1, 2 and 3 edges ago

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mDuty[k]   = 0;
         mTarget[k] = 0;
         mState[k]  = 0;
         mQuiet[k]  = 0;
      end
      phase      = 0;
      sinceReset = 0;
      for (int i = 0; i < 3; i++) seen[i] = 3'b000;
   endtask

   task automatic modelEdge();
      logic [2:0] hsNow, hpNow;
      bit         bad, hChange, tick, expire;
      int         nQuiet;
      hsNow   = seen[1];
      hpNow   = seen[2];
      bad     = (sinceReset >= 2) && ((hsNow == 3'b000) || (hsNow == 3'b111));
      hChange = (hsNow != hpNow);
      tick    = (phase == StepDiv - 1);
      for (int k = 0; k < 2; k++) begin
         expire = StallEn && (mState[k] == 0) && (mQuiet[k] == StallCycles - 1);
         if (hChange || mDuty[k] == 0 || mState[k] != 0) nQuiet = 0;
         else nQuiet = (mQuiet[k] < StallCycles - 1) ? mQuiet[k] + 1 : mQuiet[k];
         if (mState[k] == 0) begin
            if (bad || expire) begin
               mState[k]  = bad ? 1 : 2;
               mDuty[k]   = 0;
               mTarget[k] = 0;
            end else begin
               if (tick) begin
                  if (mDuty[k] < mTarget[k])
                     mDuty[k] = (mDuty[k] + stepOf[k] > mTarget[k]) ? mTarget[k]
                                                                    : mDuty[k] + stepOf[k];
                  else if (mDuty[k] > mTarget[k])
                     mDuty[k] = (mDuty[k] - stepOf[k] < mTarget[k]) ? mTarget[k]
                                                                    : mDuty[k] - stepOf[k];
               end
               if (cmd_valid) mTarget[k] = int'(cmd_duty);
            end
         end else if (cmd_valid && cmd_duty == 8'd0 && !bad) begin
            mState[k] = 0;
         end
         mQuiet[k] = nQuiet;
      end
      phase      = (phase + 1) % StepDiv;
      sinceReset = (sinceReset < 10) ? sinceReset + 1 : sinceReset;
      seen[2]    = seen[1];
      seen[1]    = seen[0];
      seen[0]    = h;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) modelReset();
      else modelEdge();
   end

   // ---------------- checking ----------------
   task automatic checkEq(input string tag, input int got, input int exp);
      nChecks++;
      if (got != exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic checkAll();
      checkEq("duty_s1",  int'(duty1),  mDuty[0]);
      checkEq("state_s1", int'(state1), mState[0]);
      checkEq("hf_s1",    int'(hf1),    (mState[0] == 1) ? 1 : 0);
      checkEq("stall_s1", int'(st1),    (mState[0] == 2) ? 1 : 0);
      checkEq("duty_s7",  int'(duty7),  mDuty[1]);
      checkEq("state_s7", int'(state7), mState[1]);
      checkEq("hf_s7",    int'(hf7),    (mState[1] == 1) ? 1 : 0);
      checkEq("stall_s7", int'(st7),    (mState[1] == 2) ? 1 : 0);
   endtask

   // ---------------- hall stimulus ----------------
   logic [2:0] hallSeq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
   int  hallIdx  = 0;
   int  hallCnt  = 0;
   bit  hallHold = 1'b0;

   task automatic hallAdvance();
      if (!hallHold) begin
         hallCnt++;
         if (hallCnt >= 20) begin
            hallCnt = 0;
            hallIdx = (hallIdx + 1) % 6;
            h       = hallSeq[hallIdx];
         end
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      checkAll();
      hallAdvance();
   endtask

   task automatic sendCmd(input int d);
      cmd_duty  = 8'(d);
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      bit found;
      int r;
      bit pulse;
      reset     = 1'b1;
      cmd_duty  = 8'd0;
      cmd_valid = 1'b0;
      h         = hallSeq[0];
      cyc();
      cyc();
      reset = 1'b0;
      checkEq("reset_duty",  int'(duty1),  0);
      checkEq("reset_state", int'(state1), 0);
      checkEq("reset_hf",    int'(hf1),    0);
      checkEq("reset_stall", int'(st1),    0);
      repeat (4) cyc();

      // Ramp up to 10, then down to 3.
      sendCmd(10);
      repeat (48) cyc();
      checkEq("ramp_hold10_s1", int'(duty1), 10);
      checkEq("ramp_hold10_s7", int'(duty7), 10);
      sendCmd(3);
      repeat (40) cyc();
      checkEq("ramp_hold3_s1", int'(duty1), 3);
      checkEq("ramp_hold3_s7", int'(duty7), 3);

      // One-sample illegal hall code.
      h = 3'b111;
      cyc();
      h = hallSeq[hallIdx];
      cyc();
      cyc();
      checkEq("hallbad_state", int'(state1), 1);
      checkEq("hallbad_duty",  int'(duty1),  0);
      checkEq("hallbad_flag",  int'(hf1),    1);
      sendCmd(50);
      repeat (10) cyc();
      checkEq("fault_ignore_state", int'(state1), 1);
      checkEq("fault_ignore_duty",  int'(duty7),  0);
      sendCmd(0);
      checkEq("fault_clear_state", int'(state1), 0);
      checkEq("fault_clear_flag",  int'(hf1),    0);

      // Frozen hall with nonzero duty.
      hallHold = 1'b1;
      h        = 3'b101;
      sendCmd(20);
      repeat (1000) cyc();
      checkEq("frozen_stall",  int'(st1),   StallEn ? 1 : 0);
      checkEq("frozen_duty",   int'(duty1), StallEn ? 0 : 20);
      checkEq("frozen_stall7", int'(st7),   StallEn ? 1 : 0);
      sendCmd(0);
      checkEq("stall_clear_state", int'(state1), 0);
      repeat (100) cyc();

      // Illegal hall arriving on the same edge the watchdog would expire.
      sendCmd(30);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         if (mQuiet[0] == StallCycles - 3) found = 1'b1;
         else cyc();
      end
      checkEq("coincide_reached", int'(found), 1);
      h = 3'b000;
      repeat (3) cyc();
      checkEq("coincide_state", int'(state1), 1);
      checkEq("coincide_stall", int'(st1),    0);
      checkEq("coincide_duty",  int'(duty1),  0);
      sendCmd(0);
      checkEq("still_bad_state", int'(state1), 1);
      h = 3'b101;
      repeat (3) cyc();
      sendCmd(0);
      checkEq("bad_gone_state", int'(state1), 0);

      // Full-scale ramp, including the non-multiple step of 7.
      hallHold = 1'b0;
      sendCmd(255);
      repeat (255 * StepDiv + 12) cyc();
      checkEq("full_scale_s1", int'(duty1), 255);
      checkEq("full_scale_s7", int'(duty7), 255);

      // Reset in the middle of a ramp.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (4) cyc();
      sendCmd(200);
      repeat (60) cyc();
      checkEq("midramp_pre_s7", int'(duty7 != 8'd0), 1);
      reset = 1'b1;
      #1;
      checkEq("midramp_reset_s1", int'(duty1), 0);
      checkEq("midramp_reset_s7", int'(duty7), 0);
      cyc();
      cyc();
      reset = 1'b0;
      repeat (12) cyc();
      checkEq("after_reset_idle", int'(duty1), 0);
      sendCmd(40);
      repeat (40 * StepDiv + 8) cyc();
      checkEq("restart_ramp_s1", int'(duty1), 40);

      // Randomized commands, hall glitches and freezes.
      for (int n = 0; n < 4000; n++) begin
         r     = int'($urandom_range(0, 199));
         pulse = 1'b0;
         if (r < 8) begin
            cmd_duty  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            cmd_valid = 1'b1;
         end else if (r == 8) begin
            h     = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111;
            pulse = 1'b1;
         end else if (r == 9) begin
            hallHold = ~hallHold;
         end
         cyc();
         cmd_valid = 1'b0;
         if (pulse) h = hallSeq[hallIdx];
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
